hazard_ctrl_mc: RTL and testbench
=================================

# hazard_ctrl_mc

Parametrised next-generation hazard unit for the 5-stage MIPS pipeline. It supplies E-stage and D-stage forwarding selects plus load-use and branch stalls, with register-address width as a parameter. It adds a sequential busy tracker for the multi-cycle multiply/divide unit, stalling HI/LO readers and back-to-back MD issues. Optional performance counters are also included. It sits beside the datapath and drives the F/D stall enables and the E-stage flush.

## Interface
Parameters:
- REG_AW, 5: register address width.
- MD_LAT, 4: multiply/divide latency in cycles, ≥1.
- CNT_W, 32: perf counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- RsD, RtD, RsE, RtE  in  REG_AW  source register addresses, D and E stages.
- WriteRegE, WriteRegM, WriteRegW  in  REG_AW  destination register addresses, E/M/W stages.
- RegWriteE, RegWriteM, RegWriteW  in  1  destination write enables.
- MemtoRegE, MemtoRegM  in  1  load in E/M.
- BranchD  in  1  branch in D.
- MdStartE  in  1  MD op issuing from E this cycle.
- MdStartD, MdReadD  in  1  D holds an MD op / an mfhi/mflo.
- ForwardAE, ForwardBE  out  2  E operand select.
- ForwardAD, ForwardBD  out  1  D comparator forward from M.
- StallF, StallD, FlushE  out  1  pipeline control.
- MdBusy  out  1  MD counter nonzero.
- StallCnt, FlushCnt  out  CNT_W  perf counters.

## Operation
- Register 0 never forwards and never causes a stall.
- ForwardAE, in priority order:
  - 2'b10 if RsE==WriteRegM && RegWriteM.
  - else 2'b01 if RsE==WriteRegW && RegWriteW.
  - else 2'b00.
- ForwardBE: same rules using RtE.
- ForwardAD = RsD!=0 && RsD==WriteRegM && RegWriteM. ForwardBD: same rules using RtD.
- lwstall = MemtoRegE && (RtE==RsD || RtE==RtD).
- branchstall = BranchD && ((RegWriteE && WriteRegE∈{RsD,RtD}) || (MemtoRegM && WriteRegM∈{RsD,RtD})).
- MD tracker: counter md_cnt, width clog2(MD_LAT+1).
  - MdStartE loads MD_LAT.
  - Otherwise md_cnt decrements when nonzero.
  - MdBusy = md_cnt!=0.
- mdstall = (MdReadD || MdStartD) && (MdStartE || MdBusy).
- stall = lwstall | branchstall | mdstall. StallF = StallD = FlushE = stall.
- Boundary cases:
  - MdStartE while busy (should not occur): reload MD_LAT.
  - MD_LAT=1: reader stalls exactly 2 cycles.
  - Reset mid-count: md_cnt←0 and the stall releases next cycle.

## Timing
- Forwarding and stall outputs are combinational from the current inputs and md_cnt, with zero latency.
- While reset is high, StallF/StallD/FlushE/MdBusy are forced to 0.
- After reset: md_cnt=0 and counters=0. Forward outputs follow the inputs.
- MD timeline, MdStartE in cycle t, MD_LAT=4:
  - MdBusy is high in cycles t+1…t+4.
  - A dependent reader in D at cycle t stalls cycles t…t+4 and advances at t+5.
- Counters update on the edge following the counted cycle.

## Configuration
- HAZ_PERF_CNT_EN defined:
  - StallCnt increments each cycle StallD=1.
  - FlushCnt increments each cycle FlushE=1.
  - Both saturate at all-ones and are cleared by reset.
- Not defined: no counter flops are built, and StallCnt/FlushCnt are tied to 0.

## Structure
- Shared package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - A typedef for the forward-select type.
- Sub-module md_busy_tracker:
  - Inputs clk, reset, start.
  - Outputs busy and cnt.
  - Parameter MD_LAT.
- Stall/forward logic stays in the top-level module.

## Test plan
- RsE=1, WriteRegM=1, RegWriteM=1, WriteRegW=1, RegWriteW=1 → ForwardAE=10 (M beats W). Repeat with RsE=0 → 00.
- RsD=2, RtE=2, MemtoRegE=1 → StallF=StallD=FlushE=1. Repeat with RtD=2 and RsD=3 → same.
- BranchD=1, RsD=3, WriteRegE=3, RegWriteE=1 → stall=1. Then RsD=6, WriteRegM=6, MemtoRegM=1 → stall=1 and ForwardAD=1.
- MdStartE pulse at cycle 0 with MdReadD held high:
  - Stall cycles 0–4, release at cycle 5.
  - MdBusy high cycles 1–4.
  - With HAZ_PERF_CNT_EN: StallCnt=5, FlushCnt=5.
- Reset asserted at cycle 2 of an MD count → MdBusy=0 and stall=0 from cycle 3.
- REG_AW=6 build: RsE=33, WriteRegW=33, RegWriteW=1 → ForwardAE=01; RsE=1 → 00 (no aliasing).

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the MIPS hazard unit: forward-select encoding
// and a helper that resolves M-over-W forwarding priority.
package hazard_pkg;

  typedef logic [1:0] fwdSel_t;

  localparam fwdSel_t FWD_RF  = 2'b00;
  localparam fwdSel_t FWD_WB  = 2'b01;
  localparam fwdSel_t FWD_MEM = 2'b10;

  // The M-stage result is younger than the W-stage one, so it wins.
  function automatic fwdSel_t fwdPick(input logic memHit, input logic wbHit);
    if (memHit)     return FWD_MEM;
    else if (wbHit) return FWD_WB;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// Datapath <-> hazard unit bundle. master = datapath side, slave = hazard unit.
interface hazard_ctrl_mc_if
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] RsD, RtD, RsE, RtE;
  logic [REG_AW-1:0] WriteRegE, WriteRegM, WriteRegW;
  logic              RegWriteE, RegWriteM, RegWriteW;
  logic              MemtoRegE, MemtoRegM;
  logic              BranchD;
  logic              MdStartE, MdStartD, MdReadD;

  fwdSel_t           ForwardAE, ForwardBE;
  logic              ForwardAD, ForwardBD;
  logic              StallF, StallD, FlushE;
  logic              MdBusy;
  logic [CNT_W-1:0]  StallCnt, FlushCnt;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MdStartE, MdStartD, MdReadD,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, FlushE, MdBusy, StallCnt, FlushCnt
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MdStartE, MdStartD, MdReadD,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, FlushE, MdBusy, StallCnt, FlushCnt
  );
endinterface

// File: rtl/md_busy_tracker.sv
// Down-counter tracking the in-flight multiply/divide op; a new start reloads
// the full latency even if the unit is still busy.
module md_busy_tracker #(
  parameter int MD_LAT = 4,
  localparam int CW    = $clog2(MD_LAT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cntReg, cntNext;

  always_comb begin
    cntNext = cntReg;
    if (start)
      cntNext = CW'(MD_LAT);
    else if (cntReg != '0)
      cntNext = cntReg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cntReg <= '0;
    else       cntReg <= cntNext;
  end

  assign cnt  = cntReg;
  assign busy = (cntReg != '0);

endmodule

// File: rtl/hazard_ctrl_mc.sv
// 5-stage MIPS hazard unit with forwarding, load-use/branch/MD stalls.
// Optional stall/flush perf counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic           clk,
  input  logic           reset,
  hazard_ctrl_mc_if.slave hz
);

  localparam int MD_CW = $clog2(MD_LAT + 1);

  logic [REG_AW-1:0] srcE [2];
  logic [REG_AW-1:0] srcD [2];
  fwdSel_t           fwdE [2];
  logic [1:0]        fwdD, hitE, hitM, lwHit;
  logic              lwStall, branchStall, mdStall, stall;
  logic              mdBusy;
  logic [MD_CW-1:0]  mdCnt;

  assign srcE[0] = hz.RsE;
  assign srcE[1] = hz.RtE;
  assign srcD[0] = hz.RsD;
  assign srcD[1] = hz.RtD;

  // Index 0 is the Rs operand, index 1 the Rt operand; register 0 never matches.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gOperand
      assign fwdE[gi] = fwdPick(srcE[gi] != '0 && srcE[gi] == hz.WriteRegM && hz.RegWriteM,
                                srcE[gi] != '0 && srcE[gi] == hz.WriteRegW && hz.RegWriteW);
      assign fwdD[gi]  = srcD[gi] != '0 && srcD[gi] == hz.WriteRegM && hz.RegWriteM;
      assign hitE[gi]  = srcD[gi] != '0 && srcD[gi] == hz.WriteRegE && hz.RegWriteE;
      assign hitM[gi]  = srcD[gi] != '0 && srcD[gi] == hz.WriteRegM && hz.MemtoRegM;
      assign lwHit[gi] = srcD[gi] != '0 && srcD[gi] == hz.RtE;
    end
  endgenerate

  md_busy_tracker #(.MD_LAT(MD_LAT)) uMdTracker (
    .clk   (clk),
    .reset (reset),
    .start (hz.MdStartE),
    .busy  (mdBusy),
    .cnt   (mdCnt)
  );

  assign lwStall     = hz.MemtoRegE && (lwHit != 2'b00);
  assign branchStall = hz.BranchD && ((hitE != 2'b00) || (hitM != 2'b00));
  assign mdStall     = (hz.MdReadD || hz.MdStartD) && (hz.MdStartE || mdCnt != '0);
  assign stall       = !reset && (lwStall || branchStall || mdStall);

  assign hz.ForwardAE = fwdE[0];
  assign hz.ForwardBE = fwdE[1];
  assign hz.ForwardAD = fwdD[0];
  assign hz.ForwardBD = fwdD[1];
  assign hz.StallF    = stall;
  assign hz.StallD    = stall;
  assign hz.FlushE    = stall;
  assign hz.MdBusy    = !reset && mdBusy;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stallCntReg, flushCntReg;

  // Saturating counters; StallD and FlushE are the same signal today but are
  // counted separately so they can diverge later.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCntReg <= '0;
      flushCntReg <= '0;
    end else begin
      if (hz.StallD && stallCntReg != '1) stallCntReg <= stallCntReg + 1'b1;
      if (hz.FlushE && flushCntReg != '1) flushCntReg <= flushCntReg + 1'b1;
    end
  end

  assign hz.StallCnt = stallCntReg;
  assign hz.FlushCnt = flushCntReg;
`else
  assign hz.StallCnt = {CNT_W{1'b0}};
  assign hz.FlushCnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed self-checking bench for hazard_ctrl_mc (REG_AW=5 main DUT plus a
// REG_AW=6 instance for the wide-address aliasing check).
module tb_hazard_ctrl_mc;
  import hazard_pkg::*;

  logic clk;
  logic reset;
  int   assertCnt = 0;
  int   failCnt   = 0;

  hazard_ctrl_mc_if #(.REG_AW(5), .CNT_W(32)) hz ();
  hazard_ctrl_mc_if #(.REG_AW(6), .CNT_W(32)) hz6 ();

  hazard_ctrl_mc #(.REG_AW(5), .MD_LAT(4), .CNT_W(32)) uDut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  hazard_ctrl_mc #(.REG_AW(6), .MD_LAT(4), .CNT_W(32)) uDut6 (
    .clk   (clk),
    .reset (reset),
    .hz    (hz6.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCnt++;
    if (obs !== exp) begin
      failCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic clearIn();
    hz.RsD = '0; hz.RtD = '0; hz.RsE = '0; hz.RtE = '0;
    hz.WriteRegE = '0; hz.WriteRegM = '0; hz.WriteRegW = '0;
    hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
    hz.MemtoRegE = 0; hz.MemtoRegM = 0; hz.BranchD = 0;
    hz.MdStartE = 0; hz.MdStartD = 0; hz.MdReadD = 0;
    hz6.RsD = '0; hz6.RtD = '0; hz6.RsE = '0; hz6.RtE = '0;
    hz6.WriteRegE = '0; hz6.WriteRegM = '0; hz6.WriteRegW = '0;
    hz6.RegWriteE = 0; hz6.RegWriteM = 0; hz6.RegWriteW = 0;
    hz6.MemtoRegE = 0; hz6.MemtoRegM = 0; hz6.BranchD = 0;
    hz6.MdStartE = 0; hz6.MdStartD = 0; hz6.MdReadD = 0;
  endtask

  // Move to the next falling edge; inputs change there, outputs are checked 2ns later.
  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic checkStall(input string tag, input logic exp);
    checkVal({tag, ".StallF"}, 64'(hz.StallF), 64'(exp));
    checkVal({tag, ".StallD"}, 64'(hz.StallD), 64'(exp));
    checkVal({tag, ".FlushE"}, 64'(hz.FlushE), 64'(exp));
  endtask

  task automatic checkCnt(input string tag, input int exp);
`ifdef HAZ_PERF_CNT_EN
    checkVal({tag, ".StallCnt"}, 64'(hz.StallCnt), 64'(exp));
    checkVal({tag, ".FlushCnt"}, 64'(hz.FlushCnt), 64'(exp));
`else
    checkVal({tag, ".StallCnt"}, 64'(hz.StallCnt), 64'(0 * exp));
    checkVal({tag, ".FlushCnt"}, 64'(hz.FlushCnt), 64'(0 * exp));
`endif
  endtask

  initial begin
    clearIn();
    reset = 1'b1;

    // Reset forces stall outputs low even with a load-use hazard present.
    nextCycle();
    hz.RsD = 5'd2; hz.RtE = 5'd2; hz.MemtoRegE = 1;
    #2;
    checkStall("reset_lw", 1'b0);
    checkVal("reset.MdBusy", 64'(hz.MdBusy), 64'd0);
    nextCycle();
    reset = 1'b0;
    #2;
    checkCnt("after_reset", 0);
    checkStall("lw_rs", 1'b1);

    nextCycle();
    hz.RsD = 5'd3; hz.RtD = 5'd2;
    #2;
    checkStall("lw_rt", 1'b1);

    nextCycle();
    clearIn();
    hz.MemtoRegE = 1;
    #2;
    checkStall("lw_r0", 1'b0);

    // Forwarding priority and register-0 exclusion.
    nextCycle();
    clearIn();
    hz.RsE = 5'd1; hz.WriteRegM = 5'd1; hz.RegWriteM = 1;
    hz.WriteRegW = 5'd1; hz.RegWriteW = 1;
    #2;
    checkVal("fwdA_mem_over_wb", 64'(hz.ForwardAE), 64'(FWD_MEM));
    nextCycle();
    hz.RsE = 5'd0;
    #2;
    checkVal("fwdA_r0", 64'(hz.ForwardAE), 64'(FWD_RF));
    nextCycle();
    hz.RsE = 5'd1; hz.RegWriteM = 0; hz.RtE = 5'd1;
    #2;
    checkVal("fwdA_wb", 64'(hz.ForwardAE), 64'(FWD_WB));
    checkVal("fwdB_wb", 64'(hz.ForwardBE), 64'(FWD_WB));

    // Branch stalls against E-stage writer and M-stage load.
    nextCycle();
    clearIn();
    hz.BranchD = 1; hz.RsD = 5'd3; hz.WriteRegE = 5'd3; hz.RegWriteE = 1;
    #2;
    checkStall("br_e", 1'b1);
    nextCycle();
    hz.RegWriteE = 0;
    #2;
    checkStall("br_e_nowr", 1'b0);
    nextCycle();
    clearIn();
    hz.BranchD = 1; hz.RsD = 5'd6; hz.WriteRegM = 5'd6; hz.MemtoRegM = 1; hz.RegWriteM = 1;
    #2;
    checkStall("br_m", 1'b1);
    checkVal("br_m.ForwardAD", 64'(hz.ForwardAD), 64'd1);
    checkVal("br_m.ForwardBD", 64'(hz.ForwardBD), 64'd0);

    // Clear counters, then run the MD timeline with a reader held in D.
    nextCycle();
    clearIn();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    #2;
    checkCnt("pre_md", 0);
    nextCycle();
    hz.MdStartE = 1; hz.MdReadD = 1;
    #2;
    checkStall("md_c0", 1'b1);
    checkVal("md_c0.MdBusy", 64'(hz.MdBusy), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      nextCycle();
      hz.MdStartE = 0;
      #2;
      checkStall($sformatf("md_c%0d", k), (k <= 4));
      checkVal($sformatf("md_c%0d.MdBusy", k), 64'(hz.MdBusy), 64'(k <= 4));
    end
    checkCnt("md_done", 5);

    // Back-to-back MD issue: next MD op in D stalls behind the busy unit.
    nextCycle();
    clearIn();
    hz.MdStartE = 1;
    nextCycle();
    hz.MdStartE = 0; hz.MdStartD = 1;
    #2;
    checkStall("md_b2b", 1'b1);

    // Reset in the middle of a count drops busy and the stall.
    nextCycle();
    clearIn();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    nextCycle();
    hz.MdStartE = 1; hz.MdReadD = 1;
    nextCycle();
    hz.MdStartE = 0;
    #2;
    checkVal("mdrst_c1.MdBusy", 64'(hz.MdBusy), 64'd1);
    nextCycle();
    reset = 1'b1;
    #2;
    checkStall("mdrst_c2", 1'b0);
    nextCycle();
    reset = 1'b0;
    #2;
    checkVal("mdrst_c3.MdBusy", 64'(hz.MdBusy), 64'd0);
    checkStall("mdrst_c3", 1'b0);
    checkCnt("mdrst_c3", 0);

    // Wide-address instance: 33 must not alias onto 1.
    nextCycle();
    clearIn();
    hz6.RsE = 6'd33; hz6.WriteRegW = 6'd33; hz6.RegWriteW = 1;
    #2;
    checkVal("aw6_fwd33", 64'(hz6.ForwardAE), 64'(FWD_WB));
    nextCycle();
    hz6.RsE = 6'd1;
    #2;
    checkVal("aw6_noalias", 64'(hz6.ForwardAE), 64'(FWD_RF));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
